// File: rtl/seq_divider.sv
// Sequential unsigned radix-2 restoring divider: one quotient bit per clock,
// with registered quotient/remainder, divide-by-zero flag and a done strobe.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start
    // CALC  | one restoring step per clock, cnt counts down to 0
    // DONE  | results updated, done strobe for one cycle
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, rem, dvs;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   trial, diff;
    logic             fits;
    logic [WIDTH-1:0] q_nxt, rem_nxt;

    // Trial keeps the full remainder plus the next dividend bit, so a divisor
    // with its MSB set never overflows the compare. Borrow out of diff means
    // the divisor does not fit.
    always_comb begin
        trial   = {rem, q[WIDTH-1]};
        diff    = trial - {1'b0, dvs};
        fits    = ~diff[WIDTH];
        rem_nxt = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], fits};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor != '0) ? CALC : DONE;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            q           <= '0;
            rem         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            q   <= dividend;
                            rem <= '0;
                            dvs <= divisor;
                            cnt <= CNT_W'(WIDTH - 1);
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q   <= q_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        quotient    <= q_nxt;
                        remainder   <= rem_nxt;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule
